filter_ctrl: RTL and testbench

Frame-synchronous mode controller for the video-pipeline filter stage. Accepts filter-mode change requests from the SoC register side and applies them only at a frame boundary (rising edge of `pre_vs`). For a programmable number of frames after each switch it asserts `mute`, so downstream logic can blank output while the newly selected filter's line buffers refill. It also keeps a frame counter and an optional frame-geometry checker. It sits between the SoC peripheral registers and the `mode` input of the filter stage, monitoring the same `pre_vs`/`pre_de` stream the filter consumes.

---
 rtl/vp_pkg.sv | 31 +++
 rtl/vp_geom_chk.sv | 91 +++++++++
 rtl/filter_ctrl.sv | 151 +++++++++++++++
 tb/tb_filter_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// vp_pkg: definitions shared by the video-pipeline filter stage and its
// mode controller. Holds the mode encodings (also decoded by the filter
// stage), the controller state enum and a small saturating-counter helper.
package vp_pkg;

    // Filter mode encodings driven on filter_ctrl.mode
    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_GAUSS  = 2'b01;
    localparam logic [1:0] MODE_MEAN   = 2'b10;
    localparam logic [1:0] MODE_MEDIAN = 2'b11;

    // Width of the geometry counters (pixels per line, lines per frame)
    localparam int GEOM_CNT_W = 12;

    // Mode controller states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PEND   = 2'b01,
        SETTLE = 2'b10
    } ctrl_state_t;

    // Increment that sticks at all-ones instead of wrapping, so an absurdly
    // long line or frame still compares unequal to the expected geometry.
    function automatic logic [GEOM_CNT_W-1:0] sat_inc12(input logic [GEOM_CNT_W-1:0] value);
        if (value == {GEOM_CNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/vp_geom_chk.sv
// vp_geom_chk: frame-geometry checker for the filter stage input stream.
// Counts pre_de cycles per line and lines per frame, and raises sticky
// h_err / v_err when either differs from the expected active size.
// Only instantiated by filter_ctrl when FILTER_CTRL_GEOM_CHK_EN is defined.
module vp_geom_chk
    import vp_pkg::*;
#(
    parameter logic [11:0] IMG_HDISP = 12'd1280,
    parameter logic [11:0] IMG_VDISP = 12'd720
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pre_de,
    input  logic vs_rise,
    input  logic err_clr,
    output logic h_err,
    output logic v_err
);

    logic                  de_d;
    logic                  de_fall;
    logic                  armed;
    logic [GEOM_CNT_W-1:0] pix_cnt;
    logic [GEOM_CNT_W-1:0] line_cnt;
    logic [GEOM_CNT_W-1:0] line_cnt_eff;

    // A line ends on the cycle pre_de drops; pix_cnt still holds its width then.
    assign de_fall = de_d & ~pre_de;

    // A line ending on the same cycle as the frame boundary still belongs to
    // the frame being closed.
    assign line_cnt_eff = de_fall ? sat_inc12(line_cnt) : line_cnt;

    // Edge history of pre_de
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_d <= 1'b0;
        end else begin
            de_d <= pre_de;
        end
    end

    // Pixel counter: counts the active run, cleared whenever pre_de is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (pre_de) begin
            pix_cnt <= sat_inc12(pix_cnt);
        end else begin
            pix_cnt <= '0;
        end
    end

    // Line counter: counts completed lines, restarted at each frame boundary;
    // armed marks that a full frame has been observed since reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_cnt <= '0;
            armed    <= 1'b0;
        end else if (vs_rise) begin
            line_cnt <= '0;
            armed    <= 1'b1;
        end else if (de_fall) begin
            line_cnt <= sat_inc12(line_cnt);
        end
    end

    // Sticky line-width error; a clear wins over a same-cycle detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_err <= 1'b0;
        end else if (err_clr) begin
            h_err <= 1'b0;
        end else if (de_fall && (pix_cnt != IMG_HDISP)) begin
            h_err <= 1'b1;
        end
    end

    // Sticky line-count error; the partial frame before the first boundary
    // after reset is never judged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_err <= 1'b0;
        end else if (err_clr) begin
            v_err <= 1'b0;
        end else if (vs_rise && armed && (line_cnt_eff != IMG_VDISP)) begin
            v_err <= 1'b1;
        end
    end

endmodule

// File: rtl/filter_ctrl.sv
// filter_ctrl: frame-synchronous mode controller for the filter stage.
// Mode requests from the register side are held until the next rising edge
// of pre_vs, then applied; mute is held for SETTLE_FRAMES frames afterwards
// so downstream blanks while the new filter's line buffers refill.
// Build option: define FILTER_CTRL_GEOM_CHK_EN to include the frame-geometry
// checker (vp_geom_chk); without it h_err/v_err are constant 0.
module filter_ctrl
    import vp_pkg::*;
#(
    parameter logic [11:0] IMG_HDISP     = 12'd1280,
    parameter logic [11:0] IMG_VDISP     = 12'd720,
    parameter int          SETTLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_mode,
    input  logic        pre_vs,
    input  logic        pre_de,
    output logic [1:0]  mode,
    output logic        mute,
    output logic        busy,
    output logic [15:0] frame_cnt,
    input  logic        err_clr,
    output logic        h_err,
    output logic        v_err
);

    // Settling length in the 4-bit counter's width (legal range 0..15)
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_FRAMES);

    ctrl_state_t state;
    logic        vs_d;
    logic        vs_rise;
    logic [1:0]  pend_mode;
    logic        pend_valid;
    logic [3:0]  settle_cnt;

    assign vs_rise = pre_vs & ~vs_d;

    // Delayed vsync for frame-boundary detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= pre_vs;
        end
    end

    // Free-running frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (vs_rise) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Mode FSM: IDLE -> PEND (request held) -> SETTLE (muted) -> IDLE/PEND
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode       <= MODE_BYPASS;
            mute       <= 1'b0;
            busy       <= 1'b0;
            pend_mode  <= MODE_BYPASS;
            pend_valid <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A request for the mode already running is a no-op.
                    // A request coinciding with a boundary waits for the next one.
                    if (wr_en && (wr_mode != mode)) begin
                        pend_mode <= wr_mode;
                        busy      <= 1'b1;
                        state     <= PEND;
                    end
                end

                PEND: begin
                    if (vs_rise) begin
                        // A write landing on the boundary itself is the newest request.
                        mode       <= wr_en ? wr_mode : pend_mode;
                        pend_valid <= 1'b0;
                        if (SETTLE_INIT == 4'd0) begin
                            mute  <= 1'b0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            settle_cnt <= SETTLE_INIT;
                            mute       <= 1'b1;
                            state      <= SETTLE;
                        end
                    end else if (wr_en) begin
                        // Later requests replace earlier ones; there is no cancel.
                        pend_mode <= wr_mode;
                    end
                end

                SETTLE: begin
                    // Requests while settling are remembered but never extend the mute.
                    if (wr_en) begin
                        pend_mode  <= wr_mode;
                        pend_valid <= 1'b1;
                    end
                    if (vs_rise) begin
                        if (settle_cnt == 4'd1) begin
                            mute <= 1'b0;
                            // A remembered request switches one frame later, not now.
                            if (pend_valid || wr_en) begin
                                state <= PEND;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FILTER_CTRL_GEOM_CHK_EN
    vp_geom_chk #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_geom_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .pre_de  (pre_de),
        .vs_rise (vs_rise),
        .err_clr (err_clr),
        .h_err   (h_err),
        .v_err   (v_err)
    );
`else
    // Checker not built: flags are constant and its inputs go nowhere.
    logic unused_geom;
    assign unused_geom = ^{err_clr, pre_de, IMG_HDISP, IMG_VDISP};
    assign h_err = 1'b0;
    assign v_err = 1'b0;
`endif

endmodule

// File: tb/tb_filter_ctrl.sv
// tb_filter_ctrl: directed bench for filter_ctrl (SETTLE_FRAMES=2,
// 8x4 frame geometry). A frame-scheduling model predicts mode/mute/busy,
// frame count and geometry flags every cycle; literal checks pin key points.
// Honours FILTER_CTRL_GEOM_CHK_EN the same way the design does.
module tb_filter_ctrl;

    localparam int S = 2;
    localparam int H = 8;
    localparam int V = 4;
`ifdef FILTER_CTRL_GEOM_CHK_EN
    localparam bit GEOM = 1'b1;
`else
    localparam bit GEOM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_mode = 2'b00;
    logic        pre_vs = 1'b0;
    logic        pre_de = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  mode;
    logic        mute;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        h_err;
    logic        v_err;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    filter_ctrl #(
        .IMG_HDISP     (12'd8),
        .IMG_VDISP     (12'd4),
        .SETTLE_FRAMES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_mode   (wr_mode),
        .pre_vs    (pre_vs),
        .pre_de    (pre_de),
        .mode      (mode),
        .mute      (mute),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_clr   (err_clr),
        .h_err     (h_err),
        .v_err     (v_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model: requests scheduled onto frame numbers ----------
    int          fi;            // frame boundaries seen since reset
    logic [15:0] fc;
    logic [1:0]  cur;
    bit          pend;
    logic [1:0]  pend_val;
    int          apply_at;      // boundary number the pending request lands on
    bit          mute_act;
    int          mute_to;       // boundary number where mute ends
    bit          vs_prev, de_prev, armed, hexp, vexp;
    int          run, lines;
    logic [1:0]  exp_mode;
    bit          exp_mute, exp_busy;

    always @(posedge clk) begin
        bit rise, fall, mute_before, consumed;
        int lines_eff;
        if (!rst_n) begin
            fi = 0; fc = 0; cur = 2'b00; pend = 0; pend_val = 0; apply_at = 0;
            mute_act = 0; mute_to = 0; vs_prev = 0; de_prev = 0; armed = 0;
            hexp = 0; vexp = 0; run = 0; lines = 0;
            exp_mode = 2'b00; exp_mute = 0; exp_busy = 0;
        end else begin
            rise = pre_vs && !vs_prev;
            fall = de_prev && !pre_de;
            vs_prev = pre_vs;
            de_prev = pre_de;
            mute_before = mute_act && (fi < mute_to);
            if (rise) begin
                fi++;
                fc++;
            end
            consumed = 0;
            if (pend && rise && fi == apply_at) begin
                cur = wr_en ? wr_mode : pend_val;
                pend = 0;
                mute_act = (S > 0);
                mute_to = fi + S;
                consumed = wr_en;
            end
            if (wr_en && !consumed) begin
                if (pend) begin
                    pend_val = wr_mode;
                end else if (mute_before) begin
                    pend = 1; pend_val = wr_mode; apply_at = mute_to + 1;
                end else if (wr_mode != cur) begin
                    pend = 1; pend_val = wr_mode; apply_at = fi + 1;
                end
            end
            exp_mode = cur;
            exp_mute = mute_act && (fi < mute_to);
            exp_busy = pend || exp_mute;
            // geometry: run length per line, lines per frame
            lines_eff = lines + (fall ? 1 : 0);
            if (fall && run != H) hexp = 1;
            if (rise && armed && lines_eff != V) vexp = 1;
            if (err_clr) begin
                hexp = 0; vexp = 0;
            end
            if (fall) run = 0;
            if (pre_de) run++;
            if (rise) begin
                lines = 0; armed = 1;
            end else begin
                lines = lines_eff;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mode", 16'(mode), 16'(exp_mode));
            chk("mute", 16'(mute), 16'(exp_mute));
            chk("busy", 16'(busy), 16'(exp_busy));
            chk("frame_cnt", frame_cnt, fc);
            chk("h_err", 16'(h_err), 16'(GEOM & hexp));
            chk("v_err", 16'(v_err), 16'(GEOM & vexp));
        end
    end

    // One frame: 2 vsync cycles, 2 blank, then lines of width pixels + 3 blank.
    // Writes wa/va and wb/vb happen at cycle offsets within the frame (-1 = none).
    task automatic run_frame(input int nlines, input int short_line,
                             input int wa, input logic [1:0] va,
                             input int wb, input logic [1:0] vb);
        int len;
        len = 4 + nlines * (H + 3);
        for (int c = 0; c < len; c++) begin
            int rel, ln, pos, w;
            pre_vs = (c < 2);
            pre_de = 1'b0;
            if (c >= 4) begin
                rel = c - 4;
                ln = rel / (H + 3);
                pos = rel % (H + 3);
                w = (ln == short_line) ? H - 1 : H;
                pre_de = (pos < w);
            end
            wr_en = (c == wa) || (c == wb);
            wr_mode = (c == wb) ? vb : va;
            @(negedge clk);
        end
        pre_vs = 1'b0;
        pre_de = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic plain_frame();
        run_frame(V, -1, -1, 2'b00, -1, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_mode", 16'(mode), 16'd0);
        chk("rst_mute", 16'(mute), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic switch to gaussian, written mid-frame
        plain_frame();                                     // boundary 1
        run_frame(V, -1, 10, 2'b01, -1, 2'b00);            // boundary 2
        chk("basic_pend_mode", 16'(mode), 16'd0);
        chk("basic_pend_busy", 16'(busy), 16'd1);
        plain_frame();                                     // 3: applied
        chk("basic_mode", 16'(mode), 16'd1);
        chk("basic_mute1", 16'(mute), 16'd1);
        plain_frame();                                     // 4
        chk("basic_mute2", 16'(mute), 16'd1);
        plain_frame();                                     // 5: settled
        chk("basic_unmute", 16'(mute), 16'd0);
        chk("basic_idle", 16'(busy), 16'd0);
        chk("basic_frames", frame_cnt, 16'd5);

        // Overwrite in PEND, then a write during SETTLE
        run_frame(V, -1, 6, 2'b10, 20, 2'b11);             // 6
        chk("ovw_hold", 16'(mode), 16'd1);
        run_frame(V, -1, 15, 2'b10, -1, 2'b00);            // 7: 01->11
        chk("ovw_mode", 16'(mode), 16'd3);
        plain_frame();                                     // 8
        plain_frame();                                     // 9: settle end
        chk("settle_wr_mode", 16'(mode), 16'd3);
        chk("settle_wr_mute", 16'(mute), 16'd0);
        chk("settle_wr_busy", 16'(busy), 16'd1);
        plain_frame();                                     // 10: 11->10
        chk("settle_wr_apply", 16'(mode), 16'd2);
        chk("settle_wr_remute", 16'(mute), 16'd1);
        plain_frame();                                     // 11
        plain_frame();                                     // 12
        chk("settle_wr_idle", 16'(busy), 16'd0);

        // Write on the vsync-rise cycle, then a no-op write
        run_frame(V, -1, 0, 2'b01, -1, 2'b00);             // 13
        chk("simul_defer", 16'(mode), 16'd2);
        chk("simul_busy", 16'(busy), 16'd1);
        plain_frame();                                     // 14
        chk("simul_apply", 16'(mode), 16'd1);
        plain_frame();
        plain_frame();                                     // 16
        run_frame(V, -1, 10, 2'b01, -1, 2'b00);            // 17: no-op
        chk("noop_busy", 16'(busy), 16'd0);

        // Reset during SETTLE with a request latched
        run_frame(V, -1, 5, 2'b10, -1, 2'b00);             // 18
        run_frame(V, -1, 10, 2'b11, -1, 2'b00);            // 19: muted
        chk("pre_rst_mute", 16'(mute), 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_mode", 16'(mode), 16'd0);
        chk("midrst_mute", 16'(mute), 16'd0);
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_frame_cnt", frame_cnt, 16'd0);
        plain_frame();
        plain_frame();
        plain_frame();
        chk("post_rst_mode", 16'(mode), 16'd0);
        chk("post_rst_busy", 16'(busy), 16'd0);
        chk("post_rst_frames", frame_cnt, 16'd3);

        // Geometry: short line, then a 5-line frame, then clear
        chk("geom_clean_h", 16'(h_err), 16'd0);
        run_frame(V, 1, -1, 2'b00, -1, 2'b00);
        chk("geom_h_set", 16'(h_err), 16'(GEOM));
        chk("geom_v_clear", 16'(v_err), 16'd0);
        run_frame(V + 1, -1, -1, 2'b00, -1, 2'b00);
        plain_frame();
        chk("geom_v_set", 16'(v_err), 16'(GEOM));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("geom_clr_h", 16'(h_err), 16'd0);
        chk("geom_clr_v", 16'(v_err), 16'd0);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
